// File: rtl/sha_digest_acc_pkg.sv
// rtl/sha_digest_acc_pkg.sv - shared widths and SHA-256 constants for the digest accumulator
package sha_digest_acc_pkg;

    localparam int WORD_S    = 32;
    localparam int H_BLKCNT  = 8;
    localparam int H_SIZE    = WORD_S * H_BLKCNT;
    localparam int NUM_CH    = 4;
    localparam int OUT_WORDS = 8;

    // Channel index width, never narrower than one bit so a single-channel build still has a port.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int CH_W = ch_width(NUM_CH);

    // SHA-256 initial hash value; word k lives at [k*WORD_S +: WORD_S] (H0 in the low bits).
    localparam logic [H_SIZE-1:0] SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

endpackage

// File: rtl/sha_digest_acc_if.sv
// rtl/sha_digest_acc_if.sv - load/accumulate/digest bus of the digest accumulator
interface sha_digest_acc_if #(
    parameter int WORD_S    = sha_digest_acc_pkg::WORD_S,
    parameter int H_BLKCNT  = sha_digest_acc_pkg::H_BLKCNT,
    parameter int NUM_CH    = sha_digest_acc_pkg::NUM_CH,
    parameter int OUT_WORDS = sha_digest_acc_pkg::OUT_WORDS
) ();

    localparam int H_SIZE = WORD_S * H_BLKCNT;
    localparam int CH_W   = sha_digest_acc_pkg::ch_width(NUM_CH);

    logic                          load_i;
    logic [CH_W-1:0]               load_ch_i;
    logic [H_SIZE-1:0]             H_prev_i;
    logic                          acc_valid_i;
    logic                          acc_ready_o;
    logic [CH_W-1:0]               acc_ch_i;
    logic                          acc_last_i;
    logic [H_SIZE-1:0]             work_i;
    logic                          dig_valid_o;
    logic                          dig_ready_i;
    logic [CH_W-1:0]               dig_ch_o;
    logic [WORD_S*OUT_WORDS-1:0]   dig_o;
    logic [NUM_CH-1:0]             loaded_o;
    logic                          err_o;

    modport master (
        output load_i, load_ch_i, H_prev_i, acc_valid_i, acc_ch_i, acc_last_i, work_i, dig_ready_i,
        input  acc_ready_o, dig_valid_o, dig_ch_o, dig_o, loaded_o, err_o
    );

    modport slave (
        input  load_i, load_ch_i, H_prev_i, acc_valid_i, acc_ch_i, acc_last_i, work_i, dig_ready_i,
        output acc_ready_o, dig_valid_o, dig_ch_o, dig_o, loaded_o, err_o
    );

endinterface

// File: rtl/sha_vec_add.sv
// rtl/sha_vec_add.sv - lane-wise modulo-2^WORD_S adder over an H-sized vector
module sha_vec_add #(
    parameter int WORD_S   = 32,
    parameter int H_BLKCNT = 8
) (
    input  logic [WORD_S*H_BLKCNT-1:0] i_a,
    input  logic [WORD_S*H_BLKCNT-1:0] i_b,
    output logic [WORD_S*H_BLKCNT-1:0] o_sum
);

    // Each lane wraps on its own; carries never cross into the neighbouring word.
    for (genvar k = 0; k < H_BLKCNT; k++) begin : g_lane
        assign o_sum[k*WORD_S +: WORD_S] = i_a[k*WORD_S +: WORD_S] + i_b[k*WORD_S +: WORD_S];
    end

endmodule

// File: rtl/sha_digest_acc.sv
// rtl/sha_digest_acc.sv - multi-channel SHA-256 H-state accumulator with registered digest output
module sha_digest_acc
    import sha_digest_acc_pkg::*;
#(
    parameter int WORD_S    = sha_digest_acc_pkg::WORD_S,
    parameter int H_BLKCNT  = sha_digest_acc_pkg::H_BLKCNT,
    parameter int NUM_CH    = sha_digest_acc_pkg::NUM_CH,
    parameter int OUT_WORDS = sha_digest_acc_pkg::OUT_WORDS
) (
    input  logic             clk,
    input  logic             reset,
    sha_digest_acc_if.slave  bus
);

    localparam int H_SIZE = WORD_S * H_BLKCNT;
    localparam int CH_W   = ch_width(NUM_CH);
    localparam int DIG_W  = WORD_S * OUT_WORDS;

    logic [H_SIZE-1:0]  r_h [NUM_CH];
    logic [NUM_CH-1:0]  r_loaded;
    logic               r_dig_valid;
    logic [CH_W-1:0]    r_dig_ch;
    logic [DIG_W-1:0]   r_dig;
    logic               r_err;

    logic               w_load_ok;
    logic               w_acc_ok;
    logic               w_ready;
    logic               w_acc_fire;
    logic               w_dig_take;
    logic [CH_W-1:0]    w_load_idx;
    logic [CH_W-1:0]    w_acc_idx;
    logic [H_SIZE-1:0]  w_h_sel;
    logic [H_SIZE-1:0]  w_sum;

    assign w_load_ok  = {1'b0, bus.load_ch_i} < (CH_W+1)'(NUM_CH);
    assign w_acc_ok   = {1'b0, bus.acc_ch_i} < (CH_W+1)'(NUM_CH);
    assign w_load_idx = w_load_ok ? bus.load_ch_i : '0;
    assign w_acc_idx  = w_acc_ok ? bus.acc_ch_i : '0;

    // A same-channel load blocks the accumulate; a stalled digest blocks everything that could emit.
    assign w_ready    = ~(bus.load_i & (bus.load_ch_i == bus.acc_ch_i)) & (~r_dig_valid | bus.dig_ready_i);
    assign w_acc_fire = bus.acc_valid_i & w_ready;
    assign w_dig_take = r_dig_valid & bus.dig_ready_i;

    assign w_h_sel = r_h[w_acc_idx];

    sha_vec_add #(
        .WORD_S   (WORD_S),
        .H_BLKCNT (H_BLKCNT)
    ) u_vec_add (
        .i_a   (w_h_sel),
        .i_b   (bus.work_i),
        .o_sum (w_sum)
    );

    // H state, loaded flags, digest register and sticky error; load is applied last so it wins on its channel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_h[c] <= '0;
            end
            r_loaded    <= '0;
            r_dig_valid <= 1'b0;
            r_dig_ch    <= '0;
            r_dig       <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_dig_take) begin
                r_dig_valid <= 1'b0;
            end
            if (w_acc_fire) begin
                if (w_acc_ok) begin
                    r_h[w_acc_idx] <= w_sum;
                    if (!r_loaded[w_acc_idx]) begin
                        r_err <= 1'b1;
                    end
                    if (bus.acc_last_i) begin
                        r_dig               <= w_sum[DIG_W-1:0];
                        r_dig_ch            <= w_acc_idx;
                        r_dig_valid         <= 1'b1;
                        r_loaded[w_acc_idx] <= 1'b0;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (bus.load_i) begin
                if (w_load_ok) begin
                    r_h[w_load_idx]      <= bus.H_prev_i;
                    r_loaded[w_load_idx] <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.acc_ready_o = w_ready;
    assign bus.dig_valid_o = r_dig_valid;
    assign bus.dig_ch_o    = r_dig_ch;
    assign bus.dig_o       = r_dig;
    assign bus.loaded_o    = r_loaded;
    assign bus.err_o       = r_err;

endmodule

// File: tb/tb_sha_digest_acc.sv
// tb/tb_sha_digest_acc.sv - self-checking bench for sha_digest_acc
module tb_sha_digest_acc;
    import sha_digest_acc_pkg::*;

    localparam int DIG_W = WORD_S * OUT_WORDS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha_digest_acc_if bus ();

    sha_digest_acc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [DIG_W-1:0] dig;
    } exp_t;
    exp_t sb[$];

    logic [H_SIZE-1:0] m_h [NUM_CH];
    logic [NUM_CH-1:0] m_loaded;
    logic              m_dv;
    logic              m_err;

    typedef struct {
        int          ch;
        logic [31:0] h0, h1, w0, w1, e0, e1;
        string       name;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [H_SIZE-1:0] act, input logic [H_SIZE-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [H_SIZE-1:0] vadd(input logic [H_SIZE-1:0] a, input logic [H_SIZE-1:0] b);
        logic [H_SIZE-1:0] r;
        for (int k = 0; k < H_BLKCNT; k++) begin
            r[k*WORD_S +: WORD_S] = a[k*WORD_S +: WORD_S] + b[k*WORD_S +: WORD_S];
        end
        return r;
    endfunction

    function automatic logic [H_SIZE-1:0] rnd_h();
        logic [H_SIZE-1:0] r;
        for (int k = 0; k < H_BLKCNT; k++) begin
            r[k*WORD_S +: WORD_S] = $urandom;
        end
        return r;
    endfunction

    task automatic idle();
        bus.load_i      = 1'b0;
        bus.load_ch_i   = '0;
        bus.H_prev_i    = '0;
        bus.acc_valid_i = 1'b0;
        bus.acc_ch_i    = '0;
        bus.acc_last_i  = 1'b0;
        bus.work_i      = '0;
        bus.dig_ready_i = 1'b1;
    endtask

    // Inputs are set at posedge+1; check at posedge+3, advance the model, then step to the next posedge+1.
    task automatic tick();
        logic              exp_ready;
        logic [CH_W-1:0]   c;
        logic [H_SIZE-1:0] s;
        #2;
        if (reset) begin
            exp_ready = !(bus.load_i && (bus.load_ch_i == bus.acc_ch_i)) && (!m_dv || bus.dig_ready_i);
            check("acc_ready", H_SIZE'(bus.acc_ready_o), H_SIZE'(exp_ready));
            check("dig_valid", H_SIZE'(bus.dig_valid_o), H_SIZE'(m_dv));
            check("err", H_SIZE'(bus.err_o), H_SIZE'(m_err));
            check("loaded", H_SIZE'(bus.loaded_o), H_SIZE'(m_loaded));
            if (m_dv && sb.size() > 0) begin
                check("dig_ch", H_SIZE'(bus.dig_ch_o), H_SIZE'(sb[0].ch));
                check("dig_data", H_SIZE'(bus.dig_o), H_SIZE'(sb[0].dig));
            end
            if (m_dv && bus.dig_ready_i) begin
                m_dv = 1'b0;
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (bus.acc_valid_i && exp_ready) begin
                c = bus.acc_ch_i;
                s = vadd(m_h[c], bus.work_i);
                m_h[c] = s;
                if (!m_loaded[c]) m_err = 1'b1;
                if (bus.acc_last_i) begin
                    sb.push_back('{ch: c, dig: s[DIG_W-1:0]});
                    m_dv        = 1'b1;
                    m_loaded[c] = 1'b0;
                end
            end
            if (bus.load_i) begin
                m_h[bus.load_ch_i]      = bus.H_prev_i;
                m_loaded[bus.load_ch_i] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) m_h[i] = '0;
            m_loaded = '0;
            m_dv     = 1'b0;
            m_err    = 1'b0;
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    logic [H_SIZE-1:0] x_h;
    logic [DIG_W-1:0]  held;

    initial begin
        vecs[0] = '{0, 32'hffffffff, 32'h00000000, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000, "wrap"};
        vecs[1] = '{1, 32'h6a09e667, 32'hbb67ae85, 32'h506e3058, 32'h00000000, 32'hba7816bf, 32'hbb67ae85, "abc"};
        vecs[2] = '{2, 32'h80000000, 32'hffffffff, 32'h80000000, 32'h00000001, 32'h00000000, 32'h00000000, "msb"};
        vecs[3] = '{3, 32'h12345678, 32'h00000001, 32'h11111111, 32'h00000002, 32'h23456789, 32'h00000003, "plain"};

        // Reset held 3 cycles with load and accumulate requests active
        idle();
        reset = 1'b0;
        bus.load_i      = 1'b1;
        bus.H_prev_i    = rnd_h();
        bus.acc_valid_i = 1'b1;
        bus.acc_ch_i    = 2'd1;
        bus.acc_last_i  = 1'b1;
        bus.work_i      = rnd_h();
        bus.dig_ready_i = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        reset = 1'b1;
        idle();
        check("rst_dig_o", H_SIZE'(bus.dig_o), '0);
        check("rst_dig_ch", H_SIZE'(bus.dig_ch_o), '0);
        check("rst_loaded", H_SIZE'(bus.loaded_o), '0);
        check("rst_dig_valid", H_SIZE'(bus.dig_valid_o), '0);
        tick();
        // H must still be zero: zero work on channel 1 yields a zero digest
        bus.acc_valid_i = 1'b1;
        bus.acc_ch_i    = 2'd1;
        bus.acc_last_i  = 1'b1;
        tick();
        idle();
        check("rst_h_zero", H_SIZE'(bus.dig_o), '0);
        tick();
        do_reset();

        // Table-driven single-block digests
        for (int i = 0; i < 4; i++) begin
            idle();
            bus.load_i    = 1'b1;
            bus.load_ch_i = CH_W'(vecs[i].ch);
            bus.H_prev_i  = {rnd_h() >> 64, vecs[i].h1, vecs[i].h0};
            tick();
            idle();
            bus.acc_valid_i = 1'b1;
            bus.acc_ch_i    = CH_W'(vecs[i].ch);
            bus.acc_last_i  = 1'b1;
            bus.work_i      = {rnd_h() >> 64, vecs[i].w1, vecs[i].w0};
            tick();
            idle();
            check({vecs[i].name, "_valid"}, H_SIZE'(bus.dig_valid_o), H_SIZE'(1));
            check({vecs[i].name, "_ch"}, H_SIZE'(bus.dig_ch_o), H_SIZE'(vecs[i].ch));
            check({vecs[i].name, "_w0"}, H_SIZE'(bus.dig_o[31:0]), H_SIZE'(vecs[i].e0));
            check({vecs[i].name, "_w1"}, H_SIZE'(bus.dig_o[63:32]), H_SIZE'(vecs[i].e1));
            tick();
        end

        // Backpressure: pending digest stalls a last on ch2 until the consumer takes it
        do_reset();
        idle();
        bus.load_i = 1'b1; bus.load_ch_i = 2'd2; bus.H_prev_i = rnd_h();
        tick();
        bus.load_ch_i = 2'd0; bus.H_prev_i = rnd_h();
        tick();
        idle();
        bus.acc_valid_i = 1'b1; bus.acc_ch_i = 2'd0; bus.acc_last_i = 1'b1; bus.work_i = rnd_h();
        tick();
        held = bus.dig_o;
        bus.dig_ready_i = 1'b0;
        bus.acc_ch_i    = 2'd2;
        bus.work_i      = rnd_h();
        repeat (3) tick();
        check("bp_ready_low", H_SIZE'(bus.acc_ready_o), '0);
        check("bp_dig_stable", H_SIZE'(bus.dig_o), H_SIZE'(held));
        bus.dig_ready_i = 1'b1;
        tick();
        idle();
        check("bp_valid_held", H_SIZE'(bus.dig_valid_o), H_SIZE'(1));
        check("bp_next_ch", H_SIZE'(bus.dig_ch_o), H_SIZE'(2));
        tick();

        // Same-channel load and accumulate: load wins, accumulate refused
        idle();
        x_h = rnd_h();
        bus.load_i = 1'b1; bus.load_ch_i = 2'd3; bus.H_prev_i = x_h;
        bus.acc_valid_i = 1'b1; bus.acc_ch_i = 2'd3; bus.acc_last_i = 1'b1; bus.work_i = rnd_h();
        #1;
        check("coll_ready", H_SIZE'(bus.acc_ready_o), '0);
        #1;
        @(posedge clk);
        #1;
        m_h[3] = x_h;
        m_loaded[3] = 1'b1;
        idle();
        bus.acc_valid_i = 1'b1; bus.acc_ch_i = 2'd3; bus.acc_last_i = 1'b1;
        tick();
        idle();
        check("coll_h", H_SIZE'(bus.dig_o), x_h);
        check("coll_err", H_SIZE'(bus.err_o), '0);
        tick();

        // Accumulate on channel 0 after its last: sticky error
        idle();
        bus.acc_valid_i = 1'b1; bus.acc_ch_i = 2'd0; bus.work_i = rnd_h();
        tick();
        idle();
        check("unl_err", H_SIZE'(bus.err_o), H_SIZE'(1));
        repeat (3) tick();
        check("unl_err_sticky", H_SIZE'(bus.err_o), H_SIZE'(1));

        // Random traffic against the model, including simultaneous loads on other channels
        do_reset();
        for (int n = 0; n < 200; n++) begin
            bus.load_i      = ($urandom_range(0, 3) == 0);
            bus.load_ch_i   = CH_W'($urandom_range(0, NUM_CH - 1));
            bus.H_prev_i    = rnd_h();
            bus.acc_valid_i = ($urandom_range(0, 1) == 1);
            bus.acc_ch_i    = CH_W'($urandom_range(0, NUM_CH - 1));
            bus.acc_last_i  = ($urandom_range(0, 2) == 0);
            bus.work_i      = rnd_h();
            bus.dig_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
